// File: rtl/core_bus_decoder_if.sv
// rtl/core_bus_decoder_if.sv - core request bus, slave fan-out and error status bundle
// The slave modport is the decoder's view; master is the core/slave-model side.
interface core_bus_decoder_if #(
  parameter int NSLV = 4
);
  logic                   core_valid_i;
  logic [31:0]            core_addr_i;
  logic [31:0]            core_wdata_i;
  logic [3:0]             core_wstrb_i;
  logic [31:0]            core_rdata_o;
  logic                   core_ready_o;
  logic [NSLV-1:0]        slv_valid_o;
  logic [31:0]            slv_addr_o;
  logic [31:0]            slv_wdata_o;
  logic [3:0]             slv_wstrb_o;
  logic [32*NSLV-1:0]     slv_rdata_i;
  logic [NSLV-1:0]        slv_ready_i;
  logic                   err_o;
  logic [31:0]            err_addr_o;
  logic [7:0]             err_cnt_o;

  modport slave (
    input  core_valid_i, core_addr_i, core_wdata_i, core_wstrb_i, slv_rdata_i, slv_ready_i,
    output core_rdata_o, core_ready_o, slv_valid_o, slv_addr_o, slv_wdata_o, slv_wstrb_o,
           err_o, err_addr_o, err_cnt_o
  );

  modport master (
    output core_valid_i, core_addr_i, core_wdata_i, core_wstrb_i, slv_rdata_i, slv_ready_i,
    input  core_rdata_o, core_ready_o, slv_valid_o, slv_addr_o, slv_wdata_o, slv_wstrb_o,
           err_o, err_addr_o, err_cnt_o
  );
endinterface

// File: rtl/core_bus_decoder.sv
// rtl/core_bus_decoder.sv - base/mask address decoder with per-access response watchdog
// Misses and slave timeouts are answered with ERR_DATA so the core never stalls forever.
module core_bus_decoder #(
  parameter int                 NSLV     = 4,
  parameter logic [32*NSLV-1:0] SLV_BASE = {NSLV{32'h0}},
  parameter logic [32*NSLV-1:0] SLV_MASK = {NSLV{32'h0}},
  parameter int                 TIMEOUT  = 255,
  parameter logic [31:0]        ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  core_bus_decoder_if.slave bus
);
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]     core_rdata_q, core_rdata_d;
  logic            core_ready_q, core_ready_d;
  logic [NSLV-1:0] slv_valid_q, slv_valid_d;
  logic [31:0]     slv_addr_q, slv_addr_d;
  logic [31:0]     slv_wdata_q, slv_wdata_d;
  logic [3:0]      slv_wstrb_q, slv_wstrb_d;
  logic            err_q, err_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic            hit;
  logic [SW-1:0]   hit_idx;
  logic            sel_ready;
  logic [31:0]     sel_rdata;
  logic            timeout;
  logic            err_flag;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((bus.core_addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign sel_ready = bus.slv_ready_i[sel_q];
  assign sel_rdata = bus.slv_rdata_i[32*sel_q +: 32];
  assign timeout   = (wait_cnt_q == LAST_WAIT);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      wait_cnt_q   <= '0;
      core_rdata_q <= '0;
      core_ready_q <= 1'b0;
      slv_valid_q  <= '0;
      slv_addr_q   <= '0;
      slv_wdata_q  <= '0;
      slv_wstrb_q  <= '0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      wait_cnt_q   <= wait_cnt_d;
      core_rdata_q <= core_rdata_d;
      core_ready_q <= core_ready_d;
      slv_valid_q  <= slv_valid_d;
      slv_addr_q   <= slv_addr_d;
      slv_wdata_q  <= slv_wdata_d;
      slv_wstrb_q  <= slv_wstrb_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.core_valid_i) state_d = hit ? ACCESS : RESP;
      ACCESS:  if (sel_ready || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so the RESP cycle sees them from flops.
  always_comb begin
    sel_d        = sel_q;
    wait_cnt_d   = wait_cnt_q;
    core_rdata_d = core_rdata_q;
    core_ready_d = 1'b0;
    slv_valid_d  = slv_valid_q;
    slv_addr_d   = slv_addr_q;
    slv_wdata_d  = slv_wdata_q;
    slv_wstrb_d  = slv_wstrb_q;
    err_d        = 1'b0;
    err_addr_d   = err_addr_q;
    err_cnt_d    = err_cnt_q;
    err_flag     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.core_valid_i) begin
          slv_addr_d  = bus.core_addr_i;
          slv_wdata_d = bus.core_wdata_i;
          slv_wstrb_d = bus.core_wstrb_i;
          wait_cnt_d  = '0;
          if (hit) begin
            sel_d       = hit_idx;
            slv_valid_d = NSLV'(1) << hit_idx;
          end else begin
            core_rdata_d = ERR_DATA;
            core_ready_d = 1'b1;
            err_flag     = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          core_rdata_d = sel_rdata;
          core_ready_d = 1'b1;
          slv_valid_d  = '0;
        end else if (timeout) begin
          core_rdata_d = ERR_DATA;
          core_ready_d = 1'b1;
          slv_valid_d  = '0;
          err_flag     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (err_flag) begin
      err_d      = 1'b1;
      err_addr_d = (state_q == IDLE) ? bus.core_addr_i : slv_addr_q;
      err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end
  end

  assign bus.core_rdata_o = core_rdata_q;
  assign bus.core_ready_o = core_ready_q;
  assign bus.slv_valid_o  = slv_valid_q;
  assign bus.slv_addr_o   = slv_addr_q;
  assign bus.slv_wdata_o  = slv_wdata_q;
  assign bus.slv_wstrb_o  = slv_wstrb_q;
  assign bus.err_o        = err_q;
  assign bus.err_addr_o   = err_addr_q;
  assign bus.err_cnt_o    = err_cnt_q;
endmodule
